// File: rtl/oled_pkg.sv
// Shared definitions for the 96x64 RGB565 OLED renderers: geometry, colours,
// mode encoding and the ring animator state type.
package oled_pkg;

    localparam int OLED_W    = 96;
    localparam int OLED_H    = 64;
    localparam int PIX_COUNT = OLED_W * OLED_H;

    typedef logic [12:0] pix_idx_t;
    typedef logic [15:0] rgb565_t;
    typedef logic [4:0]  radius_t;
    typedef logic [1:0]  mode_t;

    localparam rgb565_t ORANGE = 16'hFC00;
    localparam rgb565_t BLACK  = 16'h0000;

    localparam mode_t MODE_OFF    = 2'd0;
    localparam mode_t MODE_STATIC = 2'd1;
    localparam mode_t MODE_GROW   = 2'd2;
    localparam mode_t MODE_PULSE  = 2'd3;

    // State values equal the mode codes so a sampled mode maps straight to a state.
    typedef enum logic [1:0] {
        ST_OFF    = MODE_OFF,
        ST_STATIC = MODE_STATIC,
        ST_GROW   = MODE_GROW,
        ST_PULSE  = MODE_PULSE
    } state_e;

endpackage

// File: rtl/ring_animator_if.sv
// Pixel/animation bus between the OLED driver side (master) and the ring
// animator (slave).
interface ring_animator_if;

    oled_pkg::pix_idx_t pixel_index;
    logic               frame_tick;
    oled_pkg::mode_t    mode;
    oled_pkg::rgb565_t  color;
    oled_pkg::radius_t  r_out;
    logic               busy;

    modport master (
        output pixel_index, frame_tick, mode,
        input  color, r_out, busy
    );

    modport slave (
        input  pixel_index, frame_tick, mode,
        output color, r_out, busy
    );

endinterface

// File: rtl/ring_dist_pipe.sv
// Two-stage pipeline turning a linear pixel index into {valid, squared
// distance from (CX, CY)}; shared by the shape renderers.
module ring_dist_pipe import oled_pkg::*; #(
    parameter int W  = OLED_W,
    parameter int H  = OLED_H,
    parameter int CX = OLED_W / 2,
    parameter int CY = OLED_H / 2
) (
    input  logic        clk,
    input  logic        reset,
    input  pix_idx_t    pixel_index,
    output logic        vld_p2_q,
    output logic [14:0] d2_p2_q
);

    logic [6:0]         col, row;
    logic signed [7:0]  dx_p1_d, dx_p1_q, dy_p1_d, dy_p1_q;
    logic               vld_p1_d, vld_p1_q, vld_p2_d;
    logic signed [15:0] dx_sq, dy_sq;
    logic [14:0]        d2_p2_d;

    always_comb begin
        // Stage 1: split the index into column/row offsets from the centre.
        col      = 7'(pixel_index % pix_idx_t'(W));
        row      = 7'(pixel_index / pix_idx_t'(W));
        dx_p1_d  = $signed({1'b0, col}) - 8'(CX);
        dy_p1_d  = $signed({1'b0, row}) - 8'(CY);
        vld_p1_d = (pixel_index < pix_idx_t'(W * H));

        // Stage 2: squared Euclidean distance.
        dx_sq    = dx_p1_q * dx_p1_q;
        dy_sq    = dy_p1_q * dy_p1_q;
        d2_p2_d  = 15'(dx_sq + dy_sq);
        vld_p2_d = vld_p1_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dx_p1_q  <= '0;
            dy_p1_q  <= '0;
            vld_p1_q <= 1'b0;
            d2_p2_q  <= '0;
            vld_p2_q <= 1'b0;
        end else begin
            dx_p1_q  <= dx_p1_d;
            dy_p1_q  <= dy_p1_d;
            vld_p1_q <= vld_p1_d;
            d2_p2_q  <= d2_p2_d;
            vld_p2_q <= vld_p2_d;
        end
    end

endmodule

// File: rtl/ring_animator.sv
// Ring renderer with programmable radii and a frame-synchronous animation FSM
// (OFF / STATIC / GROW / PULSE); colour appears two cycles after pixel_index.
module ring_animator import oled_pkg::*; #(
    parameter int      W           = OLED_W,
    parameter int      H           = OLED_H,
    parameter int      CX          = 48,
    parameter int      CY          = 32,
    parameter int      R_BASE      = 14,
    parameter int      THICK       = 2,
    parameter int      R_MIN       = 8,
    parameter int      R_MAX       = 20,
    parameter int      STEP_FRAMES = 2,
    parameter rgb565_t RING_COLOR  = ORANGE
) (
    input  logic          clk25,
    input  logic          reset,
    ring_animator_if.slave bus
);

    localparam int CNT_W = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;

    state_e             state_q, state_d, req;
    radius_t            r_out_q, r_out_d, ro_q, ro_d, ri_q, ri_d;
    logic               busy_q, busy_d, dir_up_q, dir_up_d, upd_q, upd_d;
    logic [CNT_W-1:0]   step_cnt_q, step_cnt_d;
    logic               step_wrap;
    logic               vld_p2;
    logic [14:0]        d2_p2, ro_sq, ri_sq;
    rgb565_t            color_d;

    ring_dist_pipe #(.W(W), .H(H), .CX(CX), .CY(CY)) u_dist (
        .clk         (clk25),
        .reset       (reset),
        .pixel_index (bus.pixel_index),
        .vld_p2_q    (vld_p2),
        .d2_p2_q     (d2_p2)
    );

    assign step_wrap = (step_cnt_q == CNT_W'(STEP_FRAMES - 1));

    always_comb begin
        state_d    = state_q;
        r_out_d    = r_out_q;
        busy_d     = busy_q;
        dir_up_d   = dir_up_q;
        step_cnt_d = step_cnt_q;
        req        = state_e'(bus.mode);
        if (bus.frame_tick) begin
            step_cnt_d = step_wrap ? '0 : step_cnt_q + CNT_W'(1);
            if (state_q == ST_GROW && req == ST_GROW) begin
                if (step_wrap) begin
                    r_out_d = r_out_q + 5'd1;
                    if (r_out_d == radius_t'(R_BASE)) begin
                        state_d    = ST_STATIC;
                        busy_d     = 1'b0;
                        step_cnt_d = '0;
                    end
                end
            end else if (state_q == ST_PULSE && req == ST_PULSE) begin
                // Turn around on arrival so each endpoint lasts one full step period.
                if (step_wrap) begin
                    r_out_d = dir_up_q ? r_out_q + 5'd1 : r_out_q - 5'd1;
                    if (r_out_d == radius_t'(R_MAX))
                        dir_up_d = 1'b0;
                    else if (r_out_d == radius_t'(R_MIN))
                        dir_up_d = 1'b1;
                end
            end else if (req != state_q) begin
                state_d    = req;
                step_cnt_d = '0;
                busy_d     = 1'b0;
                case (req)
                    ST_STATIC: r_out_d = radius_t'(R_BASE);
                    ST_GROW: begin
                        r_out_d = '0;
                        busy_d  = 1'b1;
                    end
                    ST_PULSE: begin
                        r_out_d  = radius_t'(R_MIN);
                        dir_up_d = 1'b1;
                    end
                    default: ;
                endcase
            end else if (state_q == ST_STATIC) begin
                r_out_d = radius_t'(R_BASE);
            end
        end
    end

    // Active radii follow r_out one cycle after frame_tick, so a frame never tears.
    always_comb begin
        upd_d = bus.frame_tick;
        ro_d  = ro_q;
        ri_d  = ri_q;
        if (upd_q) begin
            ro_d = r_out_q;
            ri_d = (r_out_q > radius_t'(THICK)) ? r_out_q - radius_t'(THICK) : '0;
        end
    end

    always_comb begin
        ro_sq   = 15'(ro_q) * 15'(ro_q);
        ri_sq   = 15'(ri_q) * 15'(ri_q);
        color_d = BLACK;
        if (vld_p2 && state_q != ST_OFF && ri_sq <= d2_p2 && d2_p2 <= ro_sq)
            color_d = RING_COLOR;
    end

    always_ff @(posedge clk25) begin
        if (reset) begin
            state_q    <= ST_OFF;
            r_out_q    <= radius_t'(R_BASE);
            busy_q     <= 1'b0;
            dir_up_q   <= 1'b1;
            step_cnt_q <= '0;
            upd_q      <= 1'b0;
            ro_q       <= '0;
            ri_q       <= '0;
        end else begin
            state_q    <= state_d;
            r_out_q    <= r_out_d;
            busy_q     <= busy_d;
            dir_up_q   <= dir_up_d;
            step_cnt_q <= step_cnt_d;
            upd_q      <= upd_d;
            ro_q       <= ro_d;
            ri_q       <= ri_d;
        end
    end

    assign bus.color = color_d;
    assign bus.r_out = r_out_q;
    assign bus.busy  = busy_q;

endmodule

// File: tb/tb_ring_animator.sv
// Self-checking bench for ring_animator: scenario tasks plus randomised mode
// sequences checked against a closed-form ring/animation model.
module tb_ring_animator;

    localparam int          R_BASE = 14;
    localparam int          THICK  = 2;
    localparam int          R_MIN  = 8;
    localparam int          R_MAX  = 20;
    localparam int          STEP   = 2;
    localparam logic [15:0] RING   = 16'hFC00;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ring_animator_if bus();

    ring_animator dut (
        .clk25 (clk),
        .reset (rst),
        .bus   (bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Model: current mode-level state, ticks since entering it, applied radius.
    int m_state = 0;
    int m_k     = 0;
    int m_r     = R_BASE;

    function automatic int tri_r(int k);
        int s, p, span;
        span = R_MAX - R_MIN;
        s    = k / STEP;
        p    = s % (2 * span);
        return (p <= span) ? R_MIN + p : R_MAX - (p - span);
    endfunction

    function automatic logic [15:0] exp_color(int idx, int st, int ro);
        int col, row, d2, ri;
        if (idx >= 96 * 64 || st == 0) return 16'h0000;
        col = idx % 96;
        row = idx / 96;
        d2  = (col - 48) * (col - 48) + (row - 32) * (row - 32);
        ri  = (ro > THICK) ? ro - THICK : 0;
        return (d2 >= ri * ri && d2 <= ro * ro) ? RING : 16'h0000;
    endfunction

    function automatic int near_pix();
        int dx, dy;
        dx = int'($urandom_range(0, 44)) - 22;
        dy = int'($urandom_range(0, 44)) - 22;
        return (32 + dy) * 96 + 48 + dx;
    endfunction

    task automatic model_tick(int m);
        if (m_state == 2 && m == 2) begin
            m_k++;
            m_r = m_k / STEP;
            if (m_r >= R_BASE) begin
                m_r     = R_BASE;
                m_state = 1;
                m_k     = 0;
            end
        end else if (m_state == 3 && m == 3) begin
            m_k++;
            m_r = tri_r(m_k);
        end else if (m != m_state) begin
            m_state = m;
            m_k     = 0;
            if (m == 1) m_r = R_BASE;
            else if (m == 2) m_r = 0;
            else if (m == 3) m_r = R_MIN;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic ftick(int m);
        bus.mode       = 2'(m);
        bus.frame_tick = 1'b1;
        cyc();
        bus.frame_tick = 1'b0;
        model_tick(m);
    endtask

    task automatic show(int idx);
        bus.pixel_index = 13'(idx);
        cyc();
        cyc();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.frame_tick  = 1'b1;
        bus.mode        = 2'd3;
        bus.pixel_index = 13'd3134;
        repeat (3) cyc();
        n_total++; if (bus.r_out !== 5'(R_BASE)) $display("FAIL reset_r_out got %0d want %0d", bus.r_out, R_BASE); else n_pass++;
        n_total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy); else n_pass++;
        n_total++; if (bus.color !== 16'h0) $display("FAIL reset_color got %h want 0000", bus.color); else n_pass++;
        rst = 1'b0;
        bus.frame_tick = 1'b0;
        m_state = 0; m_k = 0; m_r = R_BASE;
        show(3134);
        n_total++; if (bus.color !== 16'h0) $display("FAIL off_color got %h want 0000", bus.color); else n_pass++;
        n_total++; if (bus.r_out !== 5'(R_BASE)) $display("FAIL off_r_out got %0d want %0d", bus.r_out, R_BASE); else n_pass++;
    endtask

    task automatic test_static();
        int          pix [5] = '{3134, 3135, 3132, 3131, 3120};
        logic [15:0] want[5] = '{16'hFC00, 16'h0, 16'hFC00, 16'h0, 16'h0};
        int idx;
        ftick(1);
        n_total++; if (bus.r_out !== 5'd14) $display("FAIL static_r_out got %0d want 14", bus.r_out); else n_pass++;
        n_total++; if (bus.busy !== 1'b0) $display("FAIL static_busy got %b want 0", bus.busy); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            show(pix[i]);
            n_total++; if (bus.color !== want[i]) $display("FAIL static_pix idx=%0d got %h want %h", pix[i], bus.color, want[i]); else n_pass++;
        end
        for (int i = 0; i < 16; i++) begin
            idx = near_pix();
            show(idx);
            n_total++; if (bus.color !== exp_color(idx, m_state, m_r)) $display("FAIL static_rand idx=%0d got %h want %h", idx, bus.color, exp_color(idx, m_state, m_r)); else n_pass++;
        end
    endtask

    task automatic test_latency();
        int seq[$];
        seq = '{3134, 3135, 6143, 6200};
        for (int i = 0; i < 20; i++)
            seq.push_back((i % 3 == 0) ? int'($urandom_range(0, 8191)) : near_pix());
        for (int i = 0; i <= seq.size(); i++) begin
            bus.pixel_index = (i < seq.size()) ? 13'(seq[i]) : 13'd0;
            cyc();
            if (i >= 1) begin
                n_total++;
                if (bus.color !== exp_color(seq[i-1], m_state, m_r))
                    $display("FAIL latency idx=%0d got %h want %h", seq[i-1], bus.color, exp_color(seq[i-1], m_state, m_r));
                else n_pass++;
            end
        end
    endtask

    task automatic test_grow();
        ftick(2);
        n_total++; if (bus.r_out !== 5'd0) $display("FAIL grow_entry_r got %0d want 0", bus.r_out); else n_pass++;
        n_total++; if (bus.busy !== 1'b1) $display("FAIL grow_entry_busy got %b want 1", bus.busy); else n_pass++;
        for (int k = 1; k <= 28; k++) begin
            ftick(2);
            n_total++; if (bus.r_out !== 5'(m_r)) $display("FAIL grow_r k=%0d got %0d want %0d", k, bus.r_out, m_r); else n_pass++;
            n_total++; if (bus.busy !== (m_state == 2)) $display("FAIL grow_busy k=%0d got %b want %b", k, bus.busy, m_state == 2); else n_pass++;
            show(3134);
            n_total++; if (bus.color !== exp_color(3134, m_state, m_r)) $display("FAIL grow_pix k=%0d got %h want %h", k, bus.color, exp_color(3134, m_state, m_r)); else n_pass++;
        end
        ftick(1);
        n_total++; if (bus.r_out !== 5'd14 || bus.busy !== 1'b0) $display("FAIL grow_done got r=%0d busy=%b want r=14 busy=0", bus.r_out, bus.busy); else n_pass++;
        // Abort a fresh GROW part-way through.
        ftick(2); ftick(2); ftick(2); ftick(2);
        n_total++; if (bus.r_out !== 5'd1 || bus.busy !== 1'b1) $display("FAIL grow_mid got r=%0d busy=%b want r=1 busy=1", bus.r_out, bus.busy); else n_pass++;
        ftick(1);
        n_total++; if (bus.r_out !== 5'd14 || bus.busy !== 1'b0) $display("FAIL grow_abort got r=%0d busy=%b want r=14 busy=0", bus.r_out, bus.busy); else n_pass++;
    endtask

    task automatic test_pulse();
        int pk[3] = '{3136, 3130, 3140};
        int idx;
        ftick(3);
        n_total++; if (bus.r_out !== 5'(R_MIN)) $display("FAIL pulse_entry got %0d want %0d", bus.r_out, R_MIN); else n_pass++;
        for (int k = 1; k <= 52; k++) begin
            ftick(3);
            n_total++; if (bus.r_out !== 5'(m_r)) $display("FAIL pulse_r k=%0d got %0d want %0d", k, bus.r_out, m_r); else n_pass++;
            n_total++; if (bus.busy !== 1'b0) $display("FAIL pulse_busy k=%0d got %b want 0", k, bus.busy); else n_pass++;
            if (m_r == R_MAX) begin
                for (int j = 0; j < 3; j++) begin
                    show(pk[j]);
                    n_total++; if (bus.color !== exp_color(pk[j], m_state, m_r)) $display("FAIL pulse_max idx=%0d got %h want %h", pk[j], bus.color, exp_color(pk[j], m_state, m_r)); else n_pass++;
                end
            end else begin
                idx = near_pix();
                show(idx);
                n_total++; if (bus.color !== exp_color(idx, m_state, m_r)) $display("FAIL pulse_pix idx=%0d got %h want %h", idx, bus.color, exp_color(idx, m_state, m_r)); else n_pass++;
            end
        end
    endtask

    task automatic test_reset_mid_pulse();
        ftick(1);
        ftick(3);
        repeat (18) ftick(3);
        n_total++; if (bus.r_out !== 5'd17) $display("FAIL rmp_r got %0d want 17", bus.r_out); else n_pass++;
        show(3136);
        n_total++; if (bus.color !== exp_color(3136, m_state, m_r)) $display("FAIL rmp_pre got %h want %h", bus.color, exp_color(3136, m_state, m_r)); else n_pass++;
        rst = 1'b1;
        bus.frame_tick = 1'b1;
        cyc();
        rst = 1'b0;
        bus.frame_tick = 1'b0;
        m_state = 0; m_k = 0; m_r = R_BASE;
        n_total++; if (bus.r_out !== 5'd14 || bus.busy !== 1'b0) $display("FAIL rmp_state got r=%0d busy=%b want r=14 busy=0", bus.r_out, bus.busy); else n_pass++;
        n_total++; if (bus.color !== 16'h0) $display("FAIL rmp_color0 got %h want 0000", bus.color); else n_pass++;
        for (int i = 0; i < 6; i++) begin
            bus.pixel_index = 13'((i % 2 == 0) ? 3136 : near_pix());
            cyc();
            n_total++; if (bus.color !== 16'h0) $display("FAIL rmp_drain cyc=%0d got %h want 0000", i, bus.color); else n_pass++;
        end
    endtask

    task automatic test_mode_glitch();
        ftick(1);
        bus.pixel_index = 13'd3134;
        for (int i = 0; i < 8; i++) begin
            bus.mode = (i % 2 == 0) ? 2'd3 : 2'd1;
            cyc();
            n_total++; if (bus.r_out !== 5'd14 || bus.busy !== 1'b0) $display("FAIL glitch_static cyc=%0d got r=%0d busy=%b want r=14 busy=0", i, bus.r_out, bus.busy); else n_pass++;
        end
        n_total++; if (bus.color !== RING) $display("FAIL glitch_color got %h want fc00", bus.color); else n_pass++;
        ftick(1);
        n_total++; if (bus.r_out !== 5'd14) $display("FAIL glitch_tick got %0d want 14", bus.r_out); else n_pass++;
        ftick(3);
        for (int i = 0; i < 6; i++) begin
            bus.mode = 2'(i % 3);
            cyc();
            n_total++; if (bus.r_out !== 5'(R_MIN)) $display("FAIL glitch_pulse cyc=%0d got %0d want %0d", i, bus.r_out, R_MIN); else n_pass++;
        end
        ftick(3);
        ftick(3);
        n_total++; if (bus.r_out !== 5'(m_r)) $display("FAIL glitch_resume got %0d want %0d", bus.r_out, m_r); else n_pass++;
    endtask

    task automatic test_random();
        int m, idx;
        m = 3;
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 3) == 0) m = int'($urandom_range(0, 3));
            repeat ($urandom_range(0, 3)) begin
                bus.mode = 2'($urandom_range(0, 3));
                cyc();
            end
            ftick(m);
            n_total++; if (bus.r_out !== 5'(m_r)) $display("FAIL rand_r t=%0d got %0d want %0d", t, bus.r_out, m_r); else n_pass++;
            n_total++; if (bus.busy !== (m_state == 2)) $display("FAIL rand_busy t=%0d got %b want %b", t, bus.busy, m_state == 2); else n_pass++;
            idx = near_pix();
            show(idx);
            n_total++; if (bus.color !== exp_color(idx, m_state, m_r)) $display("FAIL rand_pix t=%0d idx=%0d got %h want %h", t, idx, bus.color, exp_color(idx, m_state, m_r)); else n_pass++;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog timeout got running want finished");
        $fatal(1);
    end

    initial begin
        rst             = 1'b1;
        bus.frame_tick  = 1'b0;
        bus.mode        = 2'd0;
        bus.pixel_index = 13'd0;
        test_reset();
        test_static();
        test_latency();
        test_grow();
        test_pulse();
        test_reset_mid_pulse();
        test_mode_glitch();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
